mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit sitting directly upstream of the word-addressed data memory in the multicycle core. It turns the core's byte, halfword and word load/store requests (MIPS lb/lbu/lh/lhu/lw/sb/sh/sw) into aligned whole-word memory accesses. Sub-word loads are handled by lane extraction plus sign or zero extension. Sub-word stores use a read-merge-write sequence. Misaligned or illegal-size requests are rejected with an error response and never touch memory.

## Interface

Parameters
- W, 32: data/address width; `WORD_WIDTH`.

Ports
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  W  byte address.
- req_wdata  in  W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal request.
- resp_rdata  out  W  load result, extended; 0 for stores and errors.
- mem_read_en  out  1  memory read enable.
- mem_read_addr  out  W  word-aligned read address, {addr[W-1:2],2'b00}.
- mem_read_data  in  W  memory read data, combinational from mem_read_addr.
- mem_write_en  out  1  memory write enable; memory writes on the rising edge.
- mem_write_addr  out  W  word-aligned write address.
- mem_write_data  out  W  full word to write.

## Operation

- Lanes are little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always an error.
- Registered request fields are latched on acceptance: addr, size, we, signed, wdata.
- FSM states:
  - IDLE
    - req_ready=1.
    - On req_valid, latch the request fields, then branch:
      - error → RESP with err.
      - load → LOAD.
      - word store → WRITE, with merged = wdata.
      - sub-word store → MERGE.
  - LOAD
    - mem_read_en=1.
    - Extract the lane, extend it, register it into resp_rdata.
    - → RESP.
  - MERGE
    - mem_read_en=1.
    - merged = read word with the target lane replaced by wdata[7:0] or wdata[15:0].
    - → WRITE.
  - WRITE
    - mem_write_en=1 with mem_write_data=merged for exactly one cycle.
    - → RESP.
  - RESP
    - resp_valid=1, resp_err per the request, req_ready=0.
    - → IDLE.
- Memory outputs are decoded from state.
  - They are 0 when not in the active state.
  - In particular, mem_write_en is never high outside WRITE.
- Memory addresses are passed unmodified apart from the low-2-bit clear. Segment remapping stays in the memory.
- req_wdata, req_addr and the other request inputs are ignored outside IDLE.

## Timing

- Request is accepted at edge E0 (req_valid & req_ready).
- resp_valid is high in the cycle starting at:
  - E0+1 for an error.
  - E0+2 for a load or a word store.
  - E0+3 for a sub-word store.
- The next request can be accepted at the edge that ends the RESP cycle+1 (IDLE). Throughput is one request per 3–4 cycles.
- No response backpressure: resp_valid is a single-cycle pulse.
- Reset values:
  - state IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - All mem_* outputs 0.
  - req_ready=0 while rst is low, 1 after release.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately and asynchronously.
  - mem_write_en drops in the same cycle, so an in-progress WRITE before its edge is discarded.
  - No response is issued.
- resp_rdata holds its value until the next RESP. It is cleared on store/error responses.

## Test plan

- Memory word 0x8899AABB at 0x10010000:
  - lb 0x10010000 → rdata 0xFFFFFFBB.
  - lbu 0x10010001 → 0x000000AA.
  - lh 0x10010002 → 0xFFFF8899.
  - lhu 0x10010000 → 0x0000AABB.
  - Each resp_valid is at E0+2.
- sb 0x10010001, wdata 0x00000012:
  - One read of 0x10010000, then one write of 0x889912BB.
  - resp_valid at E0+3, err=0.
- sw 0x10010004, wdata 0xDEADBEEF:
  - No read, one write of 0xDEADBEEF.
  - resp_valid at E0+2.
- Error cases, each giving resp_valid=1 and resp_err=1 at E0+1, with mem_read_en and mem_write_en never asserted:
  - sh 0x10010001.
  - lw 0x10010002.
  - size 11.
- Reset pulled low during MERGE of sb:
  - No mem write occurs; no resp_valid.
  - Memory word is unchanged.
  - After release, req_ready=1 and a following lw returns the original word.
- Back-to-back requests with req_valid held high:
  - The second is accepted only after RESP.
  - req_ready is 0 in LOAD, MERGE, WRITE and RESP.

Source files
------------

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - byte/half/word load-store unit in front of a word-addressed data memory
// Sub-word loads extract and extend a lane; sub-word stores do read-merge-write.
module mem_lsu #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic         resp_err,
    output logic [W-1:0] resp_rdata,
    output logic         mem_read_en,
    output logic [W-1:0] mem_read_addr,
    input  logic [W-1:0] mem_read_data,
    output logic         mem_write_en,
    output logic [W-1:0] mem_write_addr,
    output logic [W-1:0] mem_write_data
);

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] a_addr, a_wdata, merged;
    logic [1:0]   a_size;
    logic         a_we, a_signed, a_err;
    logic         accept, req_err;
    logic [W-1:0] aligned, load_ext, lane_mask, merge_word;
    logic [4:0]   lane_sh, half_sh;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;

    assign accept  = req_valid && req_ready;
    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                 state_nxt = RESP;
                    else if (!req_we)            state_nxt = LOAD;
                    else if (req_size == 2'b10)  state_nxt = WRITE;
                    else                         state_nxt = MERGE;
                end
            end
            LOAD:    state_nxt = RESP;
            MERGE:   state_nxt = a_we ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Little-endian lanes: byte k at bits [8k+7:8k], half h at [16h+15:16h].
    assign lane_sh = {a_addr[1:0], 3'b000};
    assign half_sh = {a_addr[1], 4'b0000};
    assign rd_byte = mem_read_data[lane_sh +: 8];
    assign rd_half = mem_read_data[half_sh +: 16];

    always_comb begin
        load_ext = mem_read_data;
        case (a_size)
            2'b00:   load_ext = {{(W-8){a_signed & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{(W-16){a_signed & rd_half[15]}}, rd_half};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        lane_mask = {{(W-16){1'b0}}, 16'hFFFF} << half_sh;
        if (a_size == 2'b00)
            lane_mask = {{(W-8){1'b0}}, 8'hFF} << lane_sh;
        merge_word = (mem_read_data & ~lane_mask) | ((a_wdata << lane_sh) & lane_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_addr     <= '0;
            a_wdata    <= '0;
            a_size     <= '0;
            a_we       <= 1'b0;
            a_signed   <= 1'b0;
            a_err      <= 1'b0;
            merged     <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_addr   <= req_addr;
                        a_wdata  <= req_wdata;
                        a_size   <= req_size;
                        a_we     <= req_we;
                        a_signed <= req_signed;
                        a_err    <= req_err;
                        merged   <= req_wdata;
                        if (req_err) resp_rdata <= '0;
                    end
                end
                LOAD:    resp_rdata <= load_ext;
                MERGE:   merged     <= merge_word;
                WRITE:   resp_rdata <= '0;
                default: ;
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset kills them at once.
    assign aligned        = {a_addr[W-1:2], 2'b00};
    assign req_ready      = rst && (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign resp_err       = resp_valid && a_err;
    assign mem_read_en    = (state == LOAD) || (state == MERGE);
    assign mem_read_addr  = mem_read_en ? aligned : '0;
    assign mem_write_en   = (state == WRITE);
    assign mem_write_addr = mem_write_en ? aligned : '0;
    assign mem_write_data = mem_write_en ? merged : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu
// Driver queues expected responses; a negedge monitor checks memory traffic and responses.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read_en, mem_write_en;
    logic [31:0] resp_rdata, mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

    mem_lsu #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    logic        mem_load = 1'b1;
    logic [31:0] mem [0:15];
    assign mem_read_data = mem[mem_read_addr[5:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8899AABB;
            mem[1] <= 32'h01234567;
        end else if (mem_write_en) begin
            mem[mem_write_addr[5:2]] <= mem_write_data;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: actual %h, expected %h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    int acc_cyc = 0, nrd = 0, nwr = 0;
    bit inflight = 0;
    always @(negedge clk) begin
        if (!rst) begin
            inflight = 0;
            nrd = 0;
            nwr = 0;
        end else begin
            if (inflight) chk("ready_busy", req_ready, 0);
            if (mem_read_en) begin
                nrd++;
                if (exp_q.size() > 0) chk("read_addr", mem_read_addr, exp_q[0].addr);
            end
            if (mem_write_en) begin
                nwr++;
                if (exp_q.size() == 0) fail_now("unexpected_write");
                else begin
                    chk("write_addr", mem_write_addr, exp_q[0].addr);
                    chk("write_data", mem_write_data, exp_q[0].wdata);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_resp");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_err", resp_err, e.err);
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("read_count", nrd, e.nrd);
                    chk("write_count", nwr, e.nwr);
                end
                inflight = 0;
            end
            if (req_valid && req_ready) begin
                if (inflight) fail_now("accept_while_busy");
                inflight = 1;
                acc_cyc  = cyc;
                nrd = 0;
                nwr = 0;
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fail_now("resp_timeout");
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int n_rd, input int n_wr, input logic [31:0] wexp,
                         input bit hold, input bit wait_resp);
        exp_t e;
        bit   acc;
        e.err = err; e.rdata = rdata; e.lat = lat; e.nrd = n_rd; e.nwr = n_wr;
        e.addr = {addr[31:2], 2'b00}; e.wdata = wexp;
        exp_q.push_back(e);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                acc = 1;
            end
        end
        if (!acc) fail_now("accept_timeout");
        if (!hold) req_valid = 1'b0;
        if (wait_resp) drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_read_en", mem_read_en, 0);
        chk("rst_mem_write_en", mem_write_en, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);

        //     we    size   sgn   addr          wdata         err   rdata         lat rd wr wexp
        issue(1'b0, 2'b00, 1'b1, 32'h10010000, 32'h0,        1'b0, 32'hFFFFFFBB, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b00, 1'b0, 32'h10010001, 32'h0,        1'b0, 32'h000000AA, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0,        1'b0, 32'hFFFF8899, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h10010000, 32'h0,        1'b0, 32'h0000AABB, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, 32'h0, 0, 1);

        // sb interrupted by reset while in MERGE
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10010003; req_wdata = 32'h00000055; req_valid = 1'b1;
        @(negedge clk);
        chk("rsttest_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rsttest_merge_read", mem_read_en, 1);
        rst = 1'b0;
        #1;
        chk("rsttest_write_en", mem_write_en, 0);
        chk("rsttest_resp_valid", resp_valid, 0);
        chk("rsttest_read_en", mem_read_en, 0);
        chk("rsttest_ready_low", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rsttest_mem_word", mem[0], 32'h8899AABB);
        chk("rsttest_ready_after", req_ready, 1);
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, 32'h0, 0, 1);

        // stores
        issue(1'b1, 2'b00, 1'b0, 32'h10010001, 32'h00000012, 1'b0, 32'h0, 3, 1, 1, 32'h889912BB, 0, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h10010002, 32'hCAFE7777, 1'b0, 32'h0, 3, 1, 1, 32'h777712BB, 0, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0,        1'b0, 32'h00007777, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'hDEADBEEF, 0, 1);
        chk("mem_word1", mem[1], 32'hDEADBEEF);

        // errors: misaligned half store, misaligned word load, illegal size
        issue(1'b1, 2'b01, 1'b0, 32'h10010001, 32'h0000FFFF, 1'b1, 32'h0, 1, 0, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0,        1'b1, 32'h0, 1, 0, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b11, 1'b1, 32'h10010000, 32'h0,        1'b1, 32'h0, 1, 0, 0, 32'h0, 0, 1);
        chk("mem_word0_after_err", mem[0], 32'h777712BB);

        // back-to-back with req_valid held high
        issue(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0, 1, 0);
        issue(1'b0, 2'b00, 1'b0, 32'h10010005, 32'h0,        1'b0, 32'h000000BE, 2, 1, 0, 32'h0, 0, 1);
        issue(1'b0, 2'b00, 1'b1, 32'h10010006, 32'h0,        1'b0, 32'hFFFFFFAD, 2, 1, 0, 32'h0, 1, 0);
        issue(1'b1, 2'b00, 1'b0, 32'h10010007, 32'h000000A5, 1'b0, 32'h0, 3, 1, 1, 32'hA5ADBEEF, 0, 1);

        repeat (3) @(negedge clk);
        chk("mem_word1_final", mem[1], 32'hA5ADBEEF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
